// File: rtl/cordic_vect_if.sv
// Bus bundle for the cordic_vect complex-to-polar converter.
// master drives the sample and the start strobe; slave returns magnitude/phase.
interface cordic_vect_if;
    logic signed [15:0] Xre;
    logic signed [15:0] Xim;
    logic               st;
    logic        [16:0] MAG;
    logic        [15:0] PH;
    logic               busy;
    logic               done;

    modport master (output Xre, output Xim, output st,
                    input  MAG, input  PH,  input  busy, input done);
    modport slave  (input  Xre, input  Xim, input  st,
                    output MAG, output PH,  output busy, output done);
endinterface

// File: rtl/cordic_vect.sv
// cordic_vect: iterative CORDIC in vectoring mode, complex sample -> (MAG, PH).
// Optional feature macro: GAIN_COMP_EN adds a GAIN state that removes the
// CORDIC gain from MAG (MAG = x*39797 >> 16). Undefined: MAG is the raw x.
module cordic_vect #(
    parameter int unsigned ITER = 14,
    parameter int unsigned GW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    cordic_vect_if.slave  bus
);
    localparam int unsigned W  = 16 + GW;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, ROT, GAIN} state_t;

    state_t                state_q;
    logic [CW-1:0]         it_q;
    logic signed [W-1:0]   x_q, y_q;
    logic [15:0]           z_q;
    logic                  zero_q;
    logic [16:0]           mag_q;
    logic [15:0]           ph_q;
    logic                  busy_q, done_q;

    logic signed [W-1:0]   x_d, y_d, x_sh, y_sh, re_ext, im_ext;
    logic [15:0]           z_d;

    // Arctangent table in phase units of 2*pi/2^16
    function automatic logic [15:0] atan_lut(input logic [CW-1:0] i);
        case (i)
            5'd0:    atan_lut = 16'd8192;
            5'd1:    atan_lut = 16'd4836;
            5'd2:    atan_lut = 16'd2555;
            5'd3:    atan_lut = 16'd1297;
            5'd4:    atan_lut = 16'd651;
            5'd5:    atan_lut = 16'd326;
            5'd6:    atan_lut = 16'd163;
            5'd7:    atan_lut = 16'd81;
            5'd8:    atan_lut = 16'd41;
            5'd9:    atan_lut = 16'd20;
            5'd10:   atan_lut = 16'd10;
            5'd11:   atan_lut = 16'd5;
            5'd12:   atan_lut = 16'd3;
            5'd13:   atan_lut = 16'd1;
            5'd14:   atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

    // Sign extension of the inputs so that negating -32768 is exact
    always_comb begin
        re_ext = {{GW{bus.Xre[15]}}, bus.Xre};
        im_ext = {{GW{bus.Xim[15]}}, bus.Xim};
    end

    // One micro-rotation driving y towards zero
    always_comb begin
        x_sh = x_q >>> it_q;
        y_sh = y_q >>> it_q;
        x_d  = x_q;
        y_d  = y_q;
        z_d  = z_q;
        if (!y_q[W-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_lut(it_q);
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_lut(it_q);
        end
    end

`ifdef GAIN_COMP_EN
    logic [32:0] prod;

    // Gain compensation: unsigned 17x16 multiply, truncated by 16 bits
    always_comb begin
        prod = 33'(x_q[16:0]) * 33'(17'd39797);
    end
`endif

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            it_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            ph_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.st) begin
                        // Pre-rotate the left half plane by pi
                        if (bus.Xre[15]) begin
                            x_q <= -re_ext;
                            y_q <= -im_ext;
                            z_q <= 16'h8000;
                        end else begin
                            x_q <= re_ext;
                            y_q <= im_ext;
                            z_q <= 16'h0000;
                        end
                        zero_q  <= (bus.Xre == 16'sd0) && (bus.Xim == 16'sd0);
                        it_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    if (it_q == CW'(ITER)) begin
`ifdef GAIN_COMP_EN
                        state_q <= GAIN;
`else
                        mag_q   <= zero_q ? 17'd0 : x_q[16:0];
                        ph_q    <= zero_q ? 16'd0 : z_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
`endif
                    end else begin
                        x_q  <= x_d;
                        y_q  <= y_d;
                        z_q  <= z_d;
                        it_q <= it_q + CW'(1);
                    end
                end
`ifdef GAIN_COMP_EN
                GAIN: begin
                    mag_q   <= zero_q ? 17'd0 : prod[32:16];
                    ph_q    <= zero_q ? 16'd0 : z_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.MAG  = mag_q;
    assign bus.PH   = ph_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_cordic_vect.sv
// Directed bench for cordic_vect: reset, quadrant vectors, zero input,
// latency, back-to-back starts, ignored mid-conversion start, reset abort.
module tb_cordic_vect;
    localparam int ITER = 14;
`ifdef GAIN_COMP_EN
    localparam int LAT  = ITER + 2;
    localparam int M16K = 16384;
    localparam int T16K = 4;
    localparam int MBIG = 46341;
    localparam int TBIG = 8;
`else
    localparam int LAT  = ITER + 1;
    localparam int M16K = 26981;
    localparam int T16K = 6;
    localparam int MBIG = 76312;
    localparam int TBIG = 12;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cordic_vect_if bus ();

    cordic_vect #(.ITER(ITER), .GW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Tolerance compare; wrap16 treats the values as phases modulo 2^16
    task automatic check(input string tag, input int obs, input int exp,
                         input int tol, input bit wrap16);
        int d;
        n_tests++;
        d = obs - exp;
        if (wrap16) d = int'($signed(16'(d)));
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic start(input int re, input int im);
        @(negedge clk);
        bus.Xre = 16'(re);
        bus.Xim = 16'(im);
        bus.st  = 1'b1;
        @(posedge clk);
        #1;
        bus.st  = 1'b0;
    endtask

    // Edges after the capture edge until done is seen; -1 on timeout
    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) return;
        end
        n = -1;
    endtask

    task automatic convert(input string tag, input int re, input int im,
                           input int emag, input int tmag,
                           input int eph, input int tph);
        int n;
        start(re, im);
        check({tag, "_busy"}, int'(bus.busy), 1, 0, 1'b0);
        wait_done(n);
        check({tag, "_lat"}, n, LAT, 0, 1'b0);
        check({tag, "_mag"}, int'(bus.MAG), emag, tmag, 1'b0);
        check({tag, "_ph"}, int'(bus.PH), eph, tph, 1'b1);
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, int'(bus.done), 0, 0, 1'b0);
    endtask

    initial begin
        int dones [$];
        int n, cnt, smag, sph;

        rst     = 1'b1;
        bus.Xre = 16'sd0;
        bus.Xim = 16'sd0;
        bus.st  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mag", int'(bus.MAG), 0, 0, 1'b0);
        check("rst_ph", int'(bus.PH), 0, 0, 1'b0);
        check("rst_busy", int'(bus.busy), 0, 0, 1'b0);
        check("rst_done", int'(bus.done), 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        convert("p16k", 16384, 0, M16K, T16K, 0, 2);
        convert("p30deg", 14189, 8192, M16K, T16K, 5461, 4);
        convert("m90deg", 0, -16384, M16K, T16K, 49152, 4);
        convert("p180deg", -16384, 0, M16K, T16K, 32768, 2);
        convert("corner", -32768, -32768, MBIG, TBIG, 40960, 4);
        convert("zero", 0, 0, 0, 0, 0, 0);

        // st held high: a new conversion starts in every done cycle
        @(negedge clk);
        bus.Xre = 16'sd16384;
        bus.Xim = 16'sd0;
        bus.st  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones.push_back(c);
        end
        bus.st = 1'b0;
        check("b2b_count", dones.size(), 2, 0, 1'b0);
        if (dones.size() >= 2) begin
            check("b2b_first", dones[0], LAT, 0, 1'b0);
            check("b2b_period", dones[1] - dones[0], LAT + 1, 0, 1'b0);
        end
        check("b2b_mag", int'(bus.MAG), M16K, T16K, 1'b0);
        wait_done(n);
        check("b2b_drain", int'(n > 0), 1, 0, 1'b0);

        // start while busy is ignored and not queued
        start(16384, 0);
        repeat (4) @(negedge clk);
        bus.Xre = 16'sd0;
        bus.Xim = -16'sd16384;
        bus.st  = 1'b1;
        @(posedge clk);
        #1;
        bus.st = 1'b0;
        cnt = 0;
        smag = -1;
        sph = -1;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                cnt++;
                smag = int'(bus.MAG);
                sph  = int'(bus.PH);
            end
        end
        check("mid_count", cnt, 1, 0, 1'b0);
        check("mid_mag", smag, M16K, T16K, 1'b0);
        check("mid_ph", sph, 0, 2, 1'b1);

        // reset at iteration 5 aborts without done
        start(-16384, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mag", int'(bus.MAG), 0, 0, 1'b0);
        check("abort_ph", int'(bus.PH), 0, 0, 1'b0);
        check("abort_busy", int'(bus.busy), 0, 0, 1'b0);
        check("abort_done", int'(bus.done), 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        check("abort_nodone", cnt, 0, 0, 1'b0);
        convert("post_abort", 0, -16384, M16K, T16K, 49152, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
